window_generator: RTL
=====================

WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 64, pixels per image row (minimum 3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 64, rows per frame (minimum 3).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port sof  input  1  start-of-frame; qualifies the pixel accepted in the same cycle as pixel (0,0).
REQ-007 SHALL have port pixel_valid  input  1  pixel_in is accepted on this clock edge.
REQ-008 SHALL have port pixel_in  input  8  grayscale pixel, raster order.
REQ-009 SHALL have port windowBuffer  output  9x8 (unpacked [0:8])  3x3 window to the Sobel wrapper; row-major, [0] = top-left, [8] = bottom-right.
REQ-010 SHALL have port start_calculations  output  1  one-cycle pulse; windowBuffer holds a new valid window.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL implement three states: IDLE, FILL, ACTIVE.
REQ-014 IDLE->FILL on pixel_valid&sof; pixels with valid but without sof in IDLE SHALL be discarded.
REQ-015 FILL->ACTIVE when the first pixel of row 2 is accepted; ACTIVE->IDLE when pixel (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
REQ-016 Column counter SHALL count 0..IMG_WIDTH-1 on each accepted pixel and wrap to 0; row counter SHALL increment on each column wrap.
REQ-017 SHALL keep two line buffers of IMG_WIDTH bytes (rows r-1, r-2) plus a 3x3 shift register; window row 2 = current row, row 0 = row r-2.
REQ-018 On an accepted pixel at (r,c) with r>=2 and c>=2, the next cycle SHALL present windowBuffer[0..8] = pixels (r-2..r, c-2..c) in row-major order and pulse start_calculations once.
REQ-019 Latency SHALL be exactly one clock from accepting the completing pixel to start_calculations high.
REQ-020 No window SHALL be emitted for c<2 or r<2; exactly (IMG_WIDTH-2)x(IMG_HEIGHT-2) windows per frame.
REQ-021 windowBuffer SHALL hold its value between pulses; pixel_valid low SHALL change no state, counter or output.
REQ-022 frame_done SHALL pulse in the same cycle as the last window's start_calculations.
REQ-023 sof with pixel_valid in FILL or ACTIVE SHALL abort the frame: counters restart with this pixel as (0,0), state FILL, no window emitted for it.
REQ-024 Pixel values SHALL be passed unmodified; no arithmetic is performed on pixel data.

Reset
REQ-025 While rst is high: state IDLE, counters 0, windowBuffer all 0, start_calculations 0, frame_done 0, busy 0; line-buffer contents need not be cleared.
REQ-026 rst SHALL take priority over sof and pixel_valid in the same cycle; reset mid-frame SHALL discard the frame.

Structure
REQ-027 Package sobel_pkg SHALL hold PIXEL_W=8, WIN_SIZE=9 and the state enum type.
REQ-028 SHALL instantiate sub-module line_buffer (IMG_WIDTH-deep 8-bit delay line with enable) twice.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 16*row+col)
REQ-029 Stream frame with sof on pixel 0, continuous valid -> first start_calculations one cycle after pixel (2,2); windowBuffer = {0,1,2,16,17,18,32,33,34}.
REQ-030 Same frame -> exactly 4 start_calculations pulses; last window = {17,18,19,33,34,35,49,50,51}; frame_done coincident with it; busy low afterwards.
REQ-031 Same frame with pixel_valid low on every other cycle -> identical window values and count; outputs stable during gaps.
REQ-032 Pixels without sof while IDLE -> no pulses; busy stays 0.
REQ-033 sof re-asserted at pixel (2,1), then full frame -> no window from the aborted frame; 4 correct windows afterwards.
REQ-034 rst asserted after pixel (2,3) -> all outputs 0 next cycle; new frame after release -> 4 correct windows.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and sizes for the Sobel front end: pixel width, window size
// and the window generator's state encoding.
package sobel_pkg;

    localparam int PIXEL_W  = 8;
    localparam int WIN_SIZE = 9;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of delay: dout is the pixel that entered DEPTH enabled
// shifts ago, i.e. the pixel directly above the one currently arriving.
module line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic   clk,
    input  logic   en,
    input  pixel_t din,
    output pixel_t dout
);

    // Pixel data only; contents are meaningless until a full row has passed.
    pixel_t taps_q [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (en) begin
            taps_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    assign dout = taps_q[DEPTH-1];

endmodule

// File: rtl/window_generator.sv
// Builds 3x3 raster windows for the Sobel wrapper from a pixel stream.
//   state  | meaning
//   IDLE   | waiting for a pixel qualified by sof
//   FILL   | rows 0..1 of a frame, line buffers filling
//   ACTIVE | row 2 onward, windows emitted for columns >= 2
module window_generator
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sof,
    input  logic               pixel_valid,
    input  logic [PIXEL_W-1:0] pixel_in,
    output logic [PIXEL_W-1:0] windowBuffer [0:WIN_SIZE-1],
    output logic               start_calculations,
    output logic               frame_done,
    output logic               busy
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    pixel_t        sr_q  [0:WIN_SIZE-1];
    pixel_t        sr_d  [0:WIN_SIZE-1];
    pixel_t        win_q [0:WIN_SIZE-1];
    logic          start_q, done_q;
    logic          restart, accept, emit, last;
    pixel_t        lb1_out, lb2_out;

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_r1 (
        .clk  (clk),
        .en   (accept & ~rst),
        .din  (pixel_in),
        .dout (lb1_out)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_r2 (
        .clk  (clk),
        .en   (accept & ~rst),
        .din  (lb1_out),
        .dout (lb2_out)
    );

    // Counters point at the next expected pixel; sof forces the position to (0,0).
    always_comb begin
        restart = pixel_valid & sof;
        accept  = pixel_valid & (restart | (state_q != IDLE));
        cur_col = restart ? '0 : col_q;
        cur_row = restart ? '0 : row_q;
        last    = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        emit    = accept && (cur_col >= COL_TWO) && (cur_row >= ROW_TWO);

        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
            if (last) begin
                state_d = IDLE;
                row_d   = '0;
            end else if (restart) begin
                state_d = FILL;
            end else if (state_q == FILL && cur_row == ROW_TWO && cur_col == '0) begin
                state_d = ACTIVE;
            end
        end
    end

    always_comb begin
        sr_d = sr_q;
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                sr_d[3*i]   = sr_q[3*i+1];
                sr_d[3*i+1] = sr_q[3*i+2];
            end
            sr_d[2] = lb2_out;
            sr_d[5] = lb1_out;
            sr_d[8] = pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < WIN_SIZE; k++) begin
                sr_q[k]  <= '0;
                win_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            start_q <= emit;
            done_q  <= accept & last;
            sr_q    <= sr_d;
            // The output copy only moves on emitted windows so it holds between pulses.
            if (emit) begin
                win_q <= sr_d;
            end
        end
    end

    assign windowBuffer       = win_q;
    assign start_calculations = start_q;
    assign frame_done         = done_q;
    assign busy               = (state_q != IDLE);

endmodule
